// File: rtl/rabbit_pkg.sv
// Shared types and constants for the rabbit placement logic and its LFSR.
package rabbit_pkg;

    localparam int LED_W = 8;
    localparam int CNT_W = 24;

    // Fibonacci feedback taps of the 8-bit LFSR (maximal length, period 255)
    localparam int TAP_A = 7;
    localparam int TAP_B = 5;
    localparam int TAP_C = 4;
    localparam int TAP_D = 3;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        SHOW = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/rabbit_spawner_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; loads the seed while in reset.
module lfsr8
    import rabbit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {q_q[6:0], q_q[TAP_A] ^ q_q[TAP_B] ^ q_q[TAP_C] ^ q_q[TAP_D]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rabbit_spawner.sv
// Rabbit position owner: places a rabbit off the snake, blanks it on an eat
// request, and respawns it after a programmable hold-off.
module rabbit_spawner
    import rabbit_pkg::*;
#(
    parameter int unsigned RESPAWN_CYCLES = 1500000,
    parameter logic [7:0]  LFSR_SEED      = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] snake_led,
    input  logic             eat_req,
    output logic [LED_W-1:0] rabbit_led,
    output logic             eat_ack,
    output logic [15:0]      spawn_count,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [LED_W-1:0] rabbit_q, rabbit_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      spawn_q, spawn_d;
    logic [7:0]       lfsr_val;
    logic [LED_W-1:0] cand;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_val)
    );

    assign cand = LED_W'(1) << lfsr_val[2:0];

    // eat_req/eat_ack is a 4-phase level handshake: req rises, ack rises,
    // req falls, ack falls. The rabbit may only come back once both are low
    // and the hold-off counter has drained.
    always_comb begin
        state_d  = state_q;
        rabbit_d = rabbit_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        spawn_d  = spawn_q;
        case (state_q)
            SEEK: begin
                if ((cand & snake_led) == '0) begin
                    rabbit_d = cand;
                    spawn_d  = spawn_q + 16'd1;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (eat_req) begin
                    rabbit_d = '0;
                    ack_d    = 1'b1;
                    cnt_d    = RELOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (!eat_req) begin
                    ack_d = 1'b0;
                end
                if ((cnt_q == '0) && !eat_req && !ack_q) begin
                    state_d = SEEK;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEEK;
            rabbit_q <= '0;
            ack_q    <= 1'b0;
            cnt_q    <= '0;
            spawn_q  <= '0;
        end else begin
            state_q  <= state_d;
            rabbit_q <= rabbit_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            spawn_q  <= spawn_d;
        end
    end

    assign rabbit_led  = rabbit_q;
    assign eat_ack     = ack_q;
    assign spawn_count = spawn_q;
    assign dbg_state   = state_q;

endmodule
